// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer slice.
//   state_t          : sequencer states (BOOT, FETCH, HOLD), 2-bit encoding
//   PC_INCR          : sequential PC increment in bytes
//   ALIGN_MASK       : low PC bits that must be zero for a word-aligned target
//   RESET_PC_DEFAULT : default PC value loaded on reset
package pc_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned PC_INCR          = 4;
  localparam logic [1:0]  ALIGN_MASK       = 2'b11;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_select.sv
// Combinational redirect priority mux (jr > jump > branch_taken).
//   branch_taken/branch_target, jump/jump_target, jr/jr_target : redirect requests
//   redirect   : any redirect requested this cycle
//   target     : selected target with its low alignment bits cleared
//   misaligned : selected target had nonzero alignment bits (unregistered)
module pc_redirect_select
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         jump,
  input  logic [N-1:0] jump_target,
  input  logic         jr,
  input  logic [N-1:0] jr_target,
  output logic         redirect,
  output logic [N-1:0] target,
  output logic         misaligned
);

  logic [N-1:0] sel;

  always_comb begin
    sel      = '0;
    redirect = 1'b0;
    if (jr) begin
      sel      = jr_target;
      redirect = 1'b1;
    end else if (jump) begin
      sel      = jump_target;
      redirect = 1'b1;
    end else if (branch_taken) begin
      sel      = branch_target;
      redirect = 1'b1;
    end
  end

  assign target     = {sel[N-1:2], sel[1:0] & ~ALIGN_MASK};
  assign misaligned = redirect & (|(sel[1:0] & ALIGN_MASK));

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer.
//   clk, reset (async, active-low)
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction memory handshake
//   instr_valid/instr_ready/instr/instr_pc/pc_plus4 : decode-side hold register
//   stall : freezes acceptance of the held instruction
//   branch_taken/jump/jr and their targets : PC redirects (jr > jump > branch)
//   misaligned : one-cycle pulse when the selected redirect target was unaligned
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int unsigned  N        = 32,
  parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEFAULT)
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc,
  output logic [N-1:0] pc_plus4,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         jump,
  input  logic [N-1:0] jump_target,
  input  logic         jr,
  input  logic [N-1:0] jr_target,
  output logic         misaligned
);

  state_t       state;
  logic [N-1:0] pc;
  logic         pending;
  logic [N-1:0] pend_target;

  logic         redirect;
  logic [N-1:0] target;
  logic         mis_sel;

  pc_redirect_select #(.N(N)) u_select (
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .redirect      (redirect),
    .target        (target),
    .misaligned    (mis_sel)
  );

  assign imem_addr = pc;
  assign imem_req  = (state == FETCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      pc_plus4    <= '0;
      misaligned  <= 1'b0;
      pending     <= 1'b0;
      pend_target <= '0;
    end else begin
      misaligned <= mis_sel;
      case (state)
        BOOT: begin
          if (redirect) pc <= target;
          state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            if (redirect || pending) begin
              // Returned word belongs to a stale path: drop it and refetch.
              pc      <= redirect ? target : pend_target;
              pending <= 1'b0;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              pc_plus4    <= pc + N'(PC_INCR);
              instr_valid <= 1'b1;
              pc          <= pc + N'(PC_INCR);
              state       <= HOLD;
            end
          end else if (redirect) begin
            // Address must stay stable until ack; remember where to go next.
            pending     <= 1'b1;
            pend_target <= target;
          end
        end
        HOLD: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            pc          <= target;
            state       <= FETCH;
          end else if (instr_ready && !stall) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        misaligned;

  logic        ack_auto;
  logic        ack_man;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] DATA_XOR = 32'hDEAD_0000;

  always #5 clk = ~clk;

  // Memory model: word returned is address-tagged so the bench can predict it.
  assign imem_ack   = ack_auto ? imem_req : ack_man;
  assign imem_rdata = imem_addr ^ DATA_XOR;

  pc_fetch_sequencer #(.N(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc_plus4      (pc_plus4),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .misaligned    (misaligned)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    instr_ready = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;
    jr = 1'b0; jr_target = '0;
    ack_auto = 1'b1; ack_man = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req",   {31'd0, imem_req},    32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_addr",  imem_addr,            32'h0);
    check("rst_instr", instr,                32'h0);
    check("rst_ipc",   instr_pc,             32'h0);
    check("rst_pc4",   pc_plus4,             32'h0);
    check("rst_mis",   {31'd0, misaligned},  32'd0);
    reset = 1'b1;

    // 1: zero-wait memory, sequential fetch, valid every other cycle
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("seq_req",   {31'd0, imem_req},    32'd1);
      check("seq_addr",  imem_addr,            32'(4 * k));
      check("seq_vld0",  {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      check("seq_vld1",  {31'd0, instr_valid}, 32'd1);
      check("seq_ipc",   instr_pc,             32'(4 * k));
      check("seq_pc4",   pc_plus4,             32'(4 * k + 4));
      check("seq_instr", instr,                32'(4 * k) ^ DATA_XOR);
      check("seq_noreq", {31'd0, imem_req},    32'd0);
    end

    // 3: in HOLD at 0x8, jr and jump together -> jr wins
    instr_ready = 1'b0;
    jr = 1'b1; jr_target = 32'h100;
    jump = 1'b1; jump_target = 32'h200;
    @(negedge clk);
    jr = 1'b0; jump = 1'b0;
    check("pri_vld",  {31'd0, instr_valid}, 32'd0);
    check("pri_req",  {31'd0, imem_req},    32'd1);
    check("pri_addr", imem_addr,            32'h100);
    check("pri_mis",  {31'd0, misaligned},  32'd0);
    @(negedge clk);
    check("pri_ipc",  instr_pc,             32'h100);
    check("pri_inst", instr,                32'h100 ^ DATA_XOR);

    // 4: stall blocks acceptance even with ready
    stall = 1'b1; instr_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stl_vld", {31'd0, instr_valid}, 32'd1);
      check("stl_ipc", instr_pc,             32'h100);
      check("stl_req", {31'd0, imem_req},    32'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    check("stl_acc",  {31'd0, instr_valid}, 32'd0);
    check("stl_req2", {31'd0, imem_req},    32'd1);
    check("stl_addr", imem_addr,            32'h104);

    // 2: delayed ack with branch during wait -> word dropped, refetch at target
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ack_auto = 1'b0; ack_man = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    check("br_addr0", imem_addr, 32'h0);
    branch_taken = 1'b1; branch_target = 32'h40;
    @(negedge clk);
    branch_taken = 1'b0;
    check("br_addr1", imem_addr,         32'h0);
    check("br_req1",  {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    check("br_addr2", imem_addr, 32'h0);
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    check("br_drop",  {31'd0, instr_valid}, 32'd0);
    check("br_req3",  {31'd0, imem_req},    32'd1);
    check("br_addr3", imem_addr,            32'h40);
    ack_auto = 1'b1;
    @(negedge clk);
    check("br_vld", {31'd0, instr_valid}, 32'd1);
    check("br_ipc", instr_pc,             32'h40);

    // 5: misaligned jump target is aligned down, flag pulses one cycle
    jump = 1'b1; jump_target = 32'h1002;
    @(negedge clk);
    jump = 1'b0;
    check("mis_pulse", {31'd0, misaligned}, 32'd1);
    check("mis_addr",  imem_addr,           32'h1000);
    @(negedge clk);
    check("mis_clear", {31'd0, misaligned}, 32'd0);
    check("mis_ipc",   instr_pc,            32'h1000);

    // 6: PC wraps modulo 2^32
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    @(negedge clk);
    jump = 1'b0;
    check("wr_addr0", imem_addr, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    @(negedge clk);
    check("wr_ipc",   instr_pc,             32'hFFFF_FFFC);
    check("wr_pc4",   pc_plus4,             32'h0);
    check("wr_addr1", imem_addr,            32'h0);
    check("wr_vld",   {31'd0, instr_valid}, 32'd1);
    ack_auto = 1'b0; ack_man = 1'b0;
    @(negedge clk);
    check("wr_wait",  {31'd0, imem_req}, 32'd1);

    // Asynchronous reset mid-wait; ack held high across release is ignored
    ack_man = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("ar_req",   {31'd0, imem_req},    32'd0);
    check("ar_vld",   {31'd0, instr_valid}, 32'd0);
    check("ar_instr", instr,                32'h0);
    check("ar_ipc",   instr_pc,             32'h0);
    check("ar_pc4",   pc_plus4,             32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("late_vld", {31'd0, instr_valid}, 32'd0);
    check("late_req", {31'd0, imem_req},    32'd1);
    check("late_adr", imem_addr,            32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
